// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: scoreboard entry type, forwarding encodings and default sizes
package hazard_scoreboard_pkg;
  localparam int NREGS_DEF = 8;
  localparam int DEPTH_DEF = 3;
  localparam int MAX_RW = 6;
  localparam int FWD_RF = 0;
  localparam int FWD_STAGE0 = 1;
  // Register field is sized for up to 2**MAX_RW registers so the struct is not parametric
  typedef struct packed {
    logic v;
    logic [MAX_RW-1:0] rg;
    logic ld;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard_match.sv
// sb_match: per-stage operand match vector and youngest-match forwarding select
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int RW = 3,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [DEPTH-1:0]      live,
  input  logic                  en,
  input  logic [RW-1:0]         opr,
  output logic [DEPTH-1:0]      hit,
  output logic [SW-1:0]         sel
);
  // Scan oldest to youngest so the lowest-index match is the one left in sel
  always_comb begin
    hit = '0;
    sel = SW'(FWD_RF);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit[i] = en & live[i] & (sb[i].rg == MAX_RW'(opr));
      if (hit[i]) sel = SW'(FWD_STAGE0 + i);
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side RAW hazard detection, forwarding selects and stall counter
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int FWD_EN = 0,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W = 16,
  localparam int RW = $clog2(NREGS),
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [RW-1:0]    dec_rs,
  input  logic [RW-1:0]    dec_rt,
  input  logic             dec_rs_used,
  input  logic             dec_rt_used,
  input  logic             dec_wr_en,
  input  logic [RW-1:0]    dec_wr_reg,
  input  logic             dec_is_load,
  input  logic             ext_stall,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel_rs,
  output logic [SW-1:0]    fwd_sel_rt,
  output logic [CNT_W-1:0] stall_count
);
  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t ins;
  logic [DEPTH-1:0] live, hit_rs, hit_rt;
  logic [SW-1:0] sel_rs, sel_rt;
  logic issue;
  // With a write-before-read register file the WB stage is already visible to decode
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) live[i] = sb[i].v & ~(RF_BYPASS != 0 && i == DEPTH - 1);
  end
  sb_match #(.DEPTH(DEPTH), .RW(RW)) u_rs (
    .sb(sb), .live(live), .en(dec_valid & dec_rs_used), .opr(dec_rs), .hit(hit_rs), .sel(sel_rs)
  );
  sb_match #(.DEPTH(DEPTH), .RW(RW)) u_rt (
    .sb(sb), .live(live), .en(dec_valid & dec_rt_used), .opr(dec_rt), .hit(hit_rt), .sel(sel_rt)
  );
  assign stall = (FWD_EN != 0) ? ((hit_rs[0] | hit_rt[0]) & sb[0].ld) : |{hit_rs, hit_rt};
  assign fwd_sel_rs = (FWD_EN != 0) ? sel_rs : SW'(FWD_RF);
  assign fwd_sel_rt = (FWD_EN != 0) ? sel_rt : SW'(FWD_RF);
  assign issue = dec_valid & ~stall & ~flush & ~ext_stall;
  assign ins = issue ? '{v: dec_wr_en, rg: MAX_RW'(dec_wr_reg), ld: dec_is_load} : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else if (!ext_stall) begin
      for (int i = DEPTH - 1; i > 0; i--) sb[i] <= sb[i-1];
      sb[0] <= ins;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_count <= '0;
    else if (stall & ~ext_stall & ~flush & ~&stall_count) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the in-order pipeline, sitting beside the decode stage. Tracks the destination register of every instruction in flight between decode and writeback in a shifting scoreboard. Produces the decode stall, the per-operand forwarding selects and a saturating stall counter. Supports stall-only mode and forwarding mode, and honours a global memory-stall freeze and a branch flush.

## Interface
- `NREGS`, default 8: architectural register count; `RW = $clog2(NREGS)`.
- `DEPTH`, default 3: scoreboard stages tracked; stage 0 = EX, stage `DEPTH-1` = WB.
- `FWD_EN`, default 0: 0 = stall on any RAW match; 1 = forward, stall only on load-use.
- `RF_BYPASS`, default 1: 1 = the register file writes before it reads, so the WB stage never causes a hazard.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid` in 1: decode holds a real instruction.
- `dec_rs`, `dec_rt` in RW: source register numbers.
- `dec_rs_used`, `dec_rt_used` in 1: the source is actually read.
- `dec_wr_en` in 1: the instruction writes a register.
- `dec_wr_reg` in RW: destination register, already resolved from RegDst.
- `dec_is_load` in 1: the instruction is a memory load.
- `ext_stall` in 1: memory/cache stall; freezes the whole pipeline.
- `flush` in 1: squash the decode instruction (taken branch or jump).
- `stall` out 1: hold fetch/decode and inject a bubble.
- `fwd_sel_rs`, `fwd_sel_rt` out `$clog2(DEPTH+1)`: 0 = register file; k = forward from stage k-1.
- `stall_count` out CNT_W: saturating count of hazard-stall cycles.

## Operation
- Each scoreboard entry holds `{v, reg[RW], ld}`. Stage i is "live" when `v=1` and the stage is not excluded (`RF_BYPASS=1` excludes stage `DEPTH-1`).
- Operand match: `X_used & dec_valid & live(i) & reg(i)==dec_X`, for X in {rs, rt}.
- `FWD_EN=0`: `stall` = any operand matches any live stage. Both fwd_sel outputs are held at 0.
- `FWD_EN=1`: `stall` = an operand matches stage 0 with `ld=1` (load-use).
  - fwd_sel for each operand = 1 + index of the youngest (lowest-index) live matching stage, else 0.
  - A younger match always wins over an older one.
- Register 0 is an ordinary register; no special case.
- Issue is `dec_valid & ~stall & ~flush & ~ext_stall`.
- Scoreboard update priority, highest first:
  1. `rst`: all `v` cleared.
  2. `ext_stall`: every entry holds.
  3. Otherwise all entries shift: stage i takes stage i-1, and stage 0 takes `{dec_wr_en, dec_wr_reg, dec_is_load}` on issue, else a bubble (`v=0`).
- `flush` with `stall` in the same cycle: a bubble is inserted and the instruction is squashed, never entered.
- `stall_count` increments when `stall & ~ext_stall & ~flush`. It holds at all-ones and never wraps.

## Timing
- `stall` and the fwd_sel outputs are combinational from the decode inputs and the registered scoreboard. No added latency; they are valid in the same cycle.
- After reset: every `v=0`, `stall=0`, both fwd_sel=0, `stall_count=0`.
- Reset asserted mid-operation discards every in-flight entry on the next edge, with no partial shift.
- An issued producer reaches stage i i+1 edges after issue, ignoring freeze cycles.
- `FWD_EN=0`, `RF_BYPASS=1`, DEPTH=3: a dependent instruction directly behind its producer stalls 2 cycles.
- `FWD_EN=1`: the load-use stall lasts exactly 1 cycle. The following cycle forwards from stage 1 (`fwd_sel=2`).
- `ext_stall` cycles extend stall duration one-for-one and do not count.

## Structure
- A shared pipeline package holds:
  - the scoreboard entry struct `{v, reg, ld}`;
  - fwd_sel encoding constants `FWD_RF=0` and `FWD_STAGE0=1`;
  - the default `NREGS` and `DEPTH`.
- One sub-module, `sb_match`, is instantiated once per source operand. It is purely combinational: it takes the entry vector and an operand and returns a per-stage match vector plus the youngest-match index.
- The shift register, issue logic and counter live in the top level.

## Test plan
- Reset, then `add r3` at decode, then `add` reading `r3` next cycle, with `FWD_EN=0`. Required: `stall=1` for 2 cycles, then issue; `stall_count=2`.
- Same sequence with `FWD_EN=1`. Required: `stall=0`, `fwd_sel_rs=1`. One cycle later, a reader of r3 sees `fwd_sel=2`.
- `ld r2` followed by `add` using `r2` as rt, with `FWD_EN=1`. Required: `stall=1` for exactly 1 cycle, then `fwd_sel_rt=2`.
- r5 written in both stage 0 and stage 1, then r5 read with `FWD_EN=1`. Required: `fwd_sel=1` (youngest wins).
- `ext_stall=1` for 3 cycles while `stall=1`. Required: the scoreboard is frozen, `stall_count` is unchanged, and the stall resumes afterwards with its remaining duration.
- `flush` asserted together with a writing instruction at decode. Required: a bubble is entered and a later reader of that register sees no hazard.
- Counter saturation with `CNT_W=4` and 20 stall cycles. Required: `stall_count` holds at 15.
